// File: rtl/reservation_station_if.sv
// Dispatcher/CDB/ALU-issue bundle for the reservation station.
// Pure wiring; no latency of its own.
// rs_full is the only backpressure signal; dispatch has no ready handshake.
//
// Signals:
//   rdy, clear               global enable and flush
//   ena_rs, *_in             dispatch request from the dispatcher
//   rs_full                  flow control back to the dispatcher
//   alu_cdb_*, lsb_cdb_*     result broadcast buses snooped for wakeup
//   alu_*                    registered issue port towards the ALU
// Modports: master = dispatcher/CDB/ALU side, slave = reservation station.
interface reservation_station_if #(
   parameter int TAG_W = 5,
   parameter int OP_W  = 6,
   parameter int XLEN  = 32
);
   logic             rdy;
   logic             clear;
   logic             ena_rs;
   logic [OP_W-1:0]  optype_in;
   logic [XLEN-1:0]  pc_in;
   logic [TAG_W-1:0] Qi_in;
   logic [TAG_W-1:0] Qj_in;
   logic [XLEN-1:0]  Vi_in;
   logic [XLEN-1:0]  Vj_in;
   logic [XLEN-1:0]  imm_in;
   logic [TAG_W-1:0] dest_in;
   logic             rs_full;
   logic             alu_cdb_valid;
   logic [TAG_W-1:0] alu_cdb_tag;
   logic [XLEN-1:0]  alu_cdb_val;
   logic             lsb_cdb_valid;
   logic [TAG_W-1:0] lsb_cdb_tag;
   logic [XLEN-1:0]  lsb_cdb_val;
   logic             alu_ena;
   logic [OP_W-1:0]  alu_optype;
   logic [XLEN-1:0]  alu_pc;
   logic [XLEN-1:0]  alu_vi;
   logic [XLEN-1:0]  alu_vj;
   logic [XLEN-1:0]  alu_imm;
   logic [TAG_W-1:0] alu_dest;

   modport master (
      output rdy, clear, ena_rs, optype_in, pc_in, Qi_in, Qj_in, Vi_in, Vj_in,
             imm_in, dest_in,
             alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
             lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val,
      input  rs_full, alu_ena, alu_optype, alu_pc, alu_vi, alu_vj, alu_imm, alu_dest
   );

   modport slave (
      input  rdy, clear, ena_rs, optype_in, pc_in, Qi_in, Qj_in, Vi_in, Vj_in,
             imm_in, dest_in,
             alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
             lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val,
      output rs_full, alu_ena, alu_optype, alu_pc, alu_vi, alu_vj, alu_imm, alu_dest
   );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ALU ops, wakes operands off ALU/LSB CDBs, issues oldest-index ready op.
// Latency: ready dispatch at edge N -> alu_ena after edge N+1; CDB wakeup at edge N -> issue at edge N+1 earliest.
// Backpressure: rs_full when <=1 free slot (covers dispatcher's registered output); a dispatch with no free slot is dropped.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   rs    reservation_station_if.slave (dispatch in, CDB snoop in, rs_full out, alu_* issue out)
module reservation_station #(
   parameter int ENTRIES = 8,
   parameter int TAG_W   = 5,
   parameter int OP_W    = 6,
   parameter int XLEN    = 32
) (
   input logic                  clk,
   input logic                  rst,
   reservation_station_if.slave rs
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = IDX_W + 1;

   // Per-entry state
   logic [ENTRIES-1:0] r_busy;
   logic [OP_W-1:0]    r_op   [ENTRIES];
   logic [XLEN-1:0]    r_pc   [ENTRIES];
   logic [TAG_W-1:0]   r_qi   [ENTRIES];
   logic [TAG_W-1:0]   r_qj   [ENTRIES];
   logic [XLEN-1:0]    r_vi   [ENTRIES];
   logic [XLEN-1:0]    r_vj   [ENTRIES];
   logic [XLEN-1:0]    r_imm  [ENTRIES];
   logic [TAG_W-1:0]   r_dest [ENTRIES];

   // Issue output registers
   logic               r_alu_ena;
   logic [OP_W-1:0]    r_alu_op;
   logic [XLEN-1:0]    r_alu_pc;
   logic [XLEN-1:0]    r_alu_vi;
   logic [XLEN-1:0]    r_alu_vj;
   logic [XLEN-1:0]    r_alu_imm;
   logic [TAG_W-1:0]   r_alu_dest;

   logic [CNT_W-1:0]   w_free_cnt;
   logic               w_alloc_vld;
   logic [IDX_W-1:0]   w_alloc_idx;
   logic               w_iss_vld;
   logic [IDX_W-1:0]   w_iss_idx;
   logic [XLEN:0]      w_wk_i [ENTRIES];   // {hit, value}
   logic [XLEN:0]      w_wk_j [ENTRIES];
   logic [XLEN:0]      w_ins_i;
   logic [XLEN:0]      w_ins_j;

   // Returns {hit, value}. Tag 0 never matches; ALU bus has priority over LSB.
   function automatic logic [XLEN:0] cdb_lookup(
      input logic [TAG_W-1:0] tag,
      input logic             a_vld,
      input logic [TAG_W-1:0] a_tag,
      input logic [XLEN-1:0]  a_val,
      input logic             l_vld,
      input logic [TAG_W-1:0] l_tag,
      input logic [XLEN-1:0]  l_val
   );
      logic [XLEN:0] res;
      res = '0;
      if (tag != '0) begin
         if (a_vld && (a_tag == tag))
            res = {1'b1, a_val};
         else if (l_vld && (l_tag == tag))
            res = {1'b1, l_val};
      end
      return res;
   endfunction

   // Free count, allocation and issue select all look at registered state only,
   // so a slot freed by issue this edge is never the allocation target.
   always_comb begin
      w_free_cnt  = '0;
      w_alloc_vld = 1'b0;
      w_alloc_idx = '0;
      w_iss_vld   = 1'b0;
      w_iss_idx   = '0;
      // descending scan: the last hit written is the lowest index
      for (int e = ENTRIES - 1; e >= 0; e--) begin
         if (!r_busy[e]) begin
            w_free_cnt  = w_free_cnt + CNT_W'(1);
            w_alloc_vld = 1'b1;
            w_alloc_idx = IDX_W'(e);
         end
         if (r_busy[e] && (r_qi[e] == '0) && (r_qj[e] == '0)) begin
            w_iss_vld = 1'b1;
            w_iss_idx = IDX_W'(e);
         end
      end
   end

   always_comb begin
      for (int e = 0; e < ENTRIES; e++) begin
         w_wk_i[e] = cdb_lookup(r_qi[e], rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_val,
                                rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_val);
         w_wk_j[e] = cdb_lookup(r_qj[e], rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_val,
                                rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_val);
      end
      w_ins_i = cdb_lookup(rs.Qi_in, rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_val,
                           rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_val);
      w_ins_j = cdb_lookup(rs.Qj_in, rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_val,
                           rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_val);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         r_alu_ena  <= 1'b0;
         r_alu_op   <= '0;
         r_alu_pc   <= '0;
         r_alu_vi   <= '0;
         r_alu_vj   <= '0;
         r_alu_imm  <= '0;
         r_alu_dest <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            r_op[e]   <= '0;
            r_pc[e]   <= '0;
            r_qi[e]   <= '0;
            r_qj[e]   <= '0;
            r_vi[e]   <= '0;
            r_vj[e]   <= '0;
            r_imm[e]  <= '0;
            r_dest[e] <= '0;
         end
      end else if (rs.rdy) begin
         if (rs.clear) begin
            // flush wins over insert, wakeup and issue
            r_busy    <= '0;
            r_alu_ena <= 1'b0;
         end else begin
            // wakeup of waiting operands
            for (int e = 0; e < ENTRIES; e++) begin
               if (r_busy[e]) begin
                  if (w_wk_i[e][XLEN]) begin
                     r_qi[e] <= '0;
                     r_vi[e] <= w_wk_i[e][XLEN-1:0];
                  end
                  if (w_wk_j[e][XLEN]) begin
                     r_qj[e] <= '0;
                     r_vj[e] <= w_wk_j[e][XLEN-1:0];
                  end
               end
            end

            // issue: data outputs hold when nothing is ready
            r_alu_ena <= w_iss_vld;
            if (w_iss_vld) begin
               r_busy[w_iss_idx] <= 1'b0;
               r_alu_op          <= r_op[w_iss_idx];
               r_alu_pc          <= r_pc[w_iss_idx];
               r_alu_vi          <= r_vi[w_iss_idx];
               r_alu_vj          <= r_vj[w_iss_idx];
               r_alu_imm         <= r_imm[w_iss_idx];
               r_alu_dest        <= r_dest[w_iss_idx];
            end

            // insert into lowest free slot (never the issuing slot, which is busy)
            if (rs.ena_rs && w_alloc_vld) begin
               r_busy[w_alloc_idx] <= 1'b1;
               r_op[w_alloc_idx]   <= rs.optype_in;
               r_pc[w_alloc_idx]   <= rs.pc_in;
               r_imm[w_alloc_idx]  <= rs.imm_in;
               r_dest[w_alloc_idx] <= rs.dest_in;
               r_qi[w_alloc_idx]   <= w_ins_i[XLEN] ? '0 : rs.Qi_in;
               r_vi[w_alloc_idx]   <= w_ins_i[XLEN] ? w_ins_i[XLEN-1:0] : rs.Vi_in;
               r_qj[w_alloc_idx]   <= w_ins_j[XLEN] ? '0 : rs.Qj_in;
               r_vj[w_alloc_idx]   <= w_ins_j[XLEN] ? w_ins_j[XLEN-1:0] : rs.Vj_in;
            end
         end
      end
   end

   assign rs.rs_full    = (w_free_cnt <= CNT_W'(1));
   assign rs.alu_ena    = r_alu_ena;
   assign rs.alu_optype = r_alu_op;
   assign rs.alu_pc     = r_alu_pc;
   assign rs.alu_vi     = r_alu_vi;
   assign rs.alu_vj     = r_alu_vj;
   assign rs.alu_imm    = r_alu_imm;
   assign rs.alu_dest   = r_alu_dest;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed dispatch/CDB vectors, issue scoreboard with cycle-exact expectations.
// Expected issues (fields + cycle) are queued at stimulus time; a negedge monitor pops and compares.
// Any alu_ena with an empty queue is reported as an unexpected issue.
module tb_reservation_station;
   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_err;

   typedef struct {
      logic [31:0] vi;
      logic [31:0] vj;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [5:0]  op;
      logic [4:0]  dest;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   reservation_station_if #(.TAG_W(5), .OP_W(6), .XLEN(32)) ifc ();

   reservation_station #(.ENTRIES(8), .TAG_W(5), .OP_W(6), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .rs  (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: compare every issue against the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && ifc.alu_ena === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_issue: got alu_ena=1 dest=%0d at cycle %0d, want no issue",
                     ifc.alu_dest, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("issue_cycle", cyc, mon_e.cyc);
            chk("alu_vi", ifc.alu_vi, mon_e.vi);
            chk("alu_vj", ifc.alu_vj, mon_e.vj);
            chk("alu_pc", ifc.alu_pc, mon_e.pc);
            chk("alu_imm", ifc.alu_imm, mon_e.imm);
            chk("alu_optype", 32'(ifc.alu_optype), 32'(mon_e.op));
            chk("alu_dest", 32'(ifc.alu_dest), 32'(mon_e.dest));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifc.clear         = 1'b0;
      ifc.ena_rs        = 1'b0;
      ifc.optype_in     = '0;
      ifc.pc_in         = '0;
      ifc.Qi_in         = '0;
      ifc.Qj_in         = '0;
      ifc.Vi_in         = '0;
      ifc.Vj_in         = '0;
      ifc.imm_in        = '0;
      ifc.dest_in       = '0;
      ifc.alu_cdb_valid = 1'b0;
      ifc.alu_cdb_tag   = '0;
      ifc.alu_cdb_val   = '0;
      ifc.lsb_cdb_valid = 1'b0;
      ifc.lsb_cdb_tag   = '0;
      ifc.lsb_cdb_val   = '0;
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] qi,
                       input logic [4:0] qj, input logic [31:0] vi, input logic [31:0] vj,
                       input logic [31:0] imm, input logic [4:0] dest);
      ifc.ena_rs    = 1'b1;
      ifc.optype_in = op;
      ifc.pc_in     = pc;
      ifc.Qi_in     = qi;
      ifc.Qj_in     = qj;
      ifc.Vi_in     = vi;
      ifc.Vj_in     = vj;
      ifc.imm_in    = imm;
      ifc.dest_in   = dest;
   endtask

   // waiting entry keyed by tag t: pc=0x100+(t-10), imm=t-10, vj=t, dest=t
   task automatic fill_disp(input int t);
      disp(6'd2, 32'h100 + 32'(t - 10), 5'(t), 5'd0, 32'h0, 32'(t), 32'(t - 10), 5'(t));
   endtask

   task automatic plain_disp(input int tag, input int dest, input logic [31:0] vj);
      disp(6'd5, 32'h500 + 32'(dest), 5'(tag), 5'd0, 32'h0, vj, 32'(dest), 5'(dest));
   endtask

   task automatic alu_bc(input int tag, input logic [31:0] val);
      ifc.alu_cdb_valid = 1'b1;
      ifc.alu_cdb_tag   = 5'(tag);
      ifc.alu_cdb_val   = val;
   endtask

   task automatic lsb_bc(input int tag, input logic [31:0] val);
      ifc.lsb_cdb_valid = 1'b1;
      ifc.lsb_cdb_tag   = 5'(tag);
      ifc.lsb_cdb_val   = val;
   endtask

   task automatic push(input logic [31:0] vi, input logic [31:0] vj, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [5:0] op, input logic [4:0] dest,
                       input int ecyc);
      exp_t e;
      e.vi = vi; e.vj = vj; e.pc = pc; e.imm = imm; e.op = op; e.dest = dest; e.cyc = ecyc;
      sb.push_back(e);
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      rst      = 1'b1;
      ifc.rdy  = 1'b1;
      idle();
      repeat (2) tick();
      chk("reset_alu_ena", 32'(ifc.alu_ena), 32'd0);
      chk("reset_rs_full", 32'(ifc.rs_full), 32'd0);
      chk("reset_alu_vi", ifc.alu_vi, 32'd0);
      chk("reset_alu_dest", 32'(ifc.alu_dest), 32'd0);
      rst = 1'b0;
      tick();

      // ready insert; a tag-0 broadcast in the same cycle must not be captured
      disp(6'd1, 32'h1000, 5'd0, 5'd0, 32'd5, 32'd7, 32'h11, 5'd3);
      alu_bc(0, 32'd99);
      push(32'd5, 32'd7, 32'h1000, 32'h11, 6'd1, 5'd3, cyc + 2);
      tick(); idle(); repeat (3) tick();

      // wakeup via LSB two cycles after insert
      disp(6'd2, 32'h2000, 5'd4, 5'd0, 32'hdead, 32'd2, 32'd0, 5'd5);
      tick(); idle(); tick();
      lsb_bc(4, 32'h100);
      push(32'h100, 32'd2, 32'h2000, 32'd0, 6'd2, 5'd5, cyc + 2);
      tick(); idle(); repeat (3) tick();

      // insert bypass from ALU CDB
      disp(6'd3, 32'h3000, 5'd6, 5'd0, 32'd0, 32'h22, 32'd4, 5'd7);
      alu_bc(6, 32'd9);
      push(32'd9, 32'h22, 32'h3000, 32'd4, 6'd3, 5'd7, cyc + 2);
      tick(); idle(); repeat (3) tick();

      // both operands on one tag, same tag on both buses: ALU value wins
      disp(6'd4, 32'h4000, 5'd8, 5'd8, 32'd0, 32'd0, 32'd0, 5'd9);
      tick(); idle();
      alu_bc(8, 32'h55);
      lsb_bc(8, 32'h66);
      push(32'h55, 32'h55, 32'h4000, 32'd0, 6'd4, 5'd9, cyc + 2);
      tick(); idle(); repeat (3) tick();

      // fill: 7 waiting entries (tags 10..16)
      for (int k = 0; k < 7; k++) begin
         fill_disp(10 + k);
         tick();
         if (k == 5) chk("rs_full_6busy", 32'(ifc.rs_full), 32'd0);
      end
      idle();
      chk("rs_full_7busy", 32'(ifc.rs_full), 32'd1);
      alu_bc(10, 32'(10) << 8);
      push(32'(10) << 8, 32'd10, 32'h100, 32'd0, 6'd2, 5'd10, cyc + 2);
      tick(); idle(); tick();
      chk("rs_full_after_issue", 32'(ifc.rs_full), 32'd0);
      // tags 17,18 fill slots 0 and 7; tag 19 finds no slot and is dropped
      for (int t = 17; t < 20; t++) begin
         fill_disp(t);
         tick();
      end
      idle();
      chk("rs_full_8busy", 32'(ifc.rs_full), 32'd1);
      for (int t = 11; t < 20; t++) begin
         idle();
         if (t % 2 == 1) lsb_bc(t, 32'(t) << 8);
         else            alu_bc(t, 32'(t) << 8);
         if (t != 19)
            push(32'(t) << 8, 32'(t), 32'h100 + 32'(t - 10), 32'(t - 10), 6'd2, 5'(t), cyc + 2);
         tick();
      end
      idle(); repeat (4) tick();
      chk("rs_full_drained", 32'(ifc.rs_full), 32'd0);

      // ordering: slots 0 and 2 woken by one broadcast
      plain_disp(20, 20, 32'd1); tick();
      plain_disp(21, 21, 32'd2); tick();
      plain_disp(20, 22, 32'd3); tick();
      idle();
      alu_bc(20, 32'd7);
      push(32'd7, 32'd1, 32'h500 + 32'd20, 32'd20, 6'd5, 5'd20, cyc + 2);
      push(32'd7, 32'd3, 32'h500 + 32'd22, 32'd22, 6'd5, 5'd22, cyc + 3);
      tick(); idle(); repeat (3) tick();
      lsb_bc(21, 32'h21);
      push(32'h21, 32'd2, 32'h500 + 32'd21, 32'd21, 6'd5, 5'd21, cyc + 2);
      tick(); idle(); repeat (3) tick();

      // clear: 3 waiting + 1 ready entry that would issue on the clear edge
      plain_disp(23, 23, 32'd0); tick();
      plain_disp(24, 24, 32'd0); tick();
      plain_disp(25, 25, 32'd0); tick();
      disp(6'd6, 32'h600, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0, 5'd26); tick();
      idle();
      ifc.clear = 1'b1;
      alu_bc(23, 32'h33);
      tick(); idle();
      chk("clear_alu_ena", 32'(ifc.alu_ena), 32'd0);
      chk("clear_data_hold", 32'(ifc.alu_dest), 32'd21);
      alu_bc(23, 32'h1); tick(); idle();
      lsb_bc(24, 32'h1); tick(); idle();
      alu_bc(25, 32'h1); tick(); idle();
      repeat (3) tick();

      // freeze: rdy=0 with CDB, dispatch and clear activity for 3 cycles
      plain_disp(27, 27, 32'd1); tick(); idle();
      ifc.rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(6'd7, 32'h777, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0, 5'd30);
         alu_bc(27, 32'hbad);
         lsb_bc(27, 32'hbad);
         ifc.clear = 1'b1;
         tick();
      end
      idle();
      chk("freeze_alu_ena", 32'(ifc.alu_ena), 32'd0);
      chk("freeze_alu_dest", 32'(ifc.alu_dest), 32'd21);
      chk("freeze_alu_vi", ifc.alu_vi, 32'h21);
      chk("freeze_rs_full", 32'(ifc.rs_full), 32'd0);
      ifc.rdy = 1'b1;
      alu_bc(27, 32'h27);
      push(32'h27, 32'd1, 32'h500 + 32'd27, 32'd27, 6'd5, 5'd27, cyc + 2);
      tick(); idle(); repeat (3) tick();

      // async reset while an issue is on the outputs
      plain_disp(28, 28, 32'd0); tick();
      disp(6'd7, 32'h700, 5'd0, 5'd0, 32'haa, 32'hbb, 32'd0, 5'd29); tick();
      idle(); tick();
      chk("pre_rst_alu_ena", 32'(ifc.alu_ena), 32'd1);
      chk("pre_rst_alu_dest", 32'(ifc.alu_dest), 32'd29);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_alu_ena", 32'(ifc.alu_ena), 32'd0);
      chk("async_rst_alu_vi", ifc.alu_vi, 32'd0);
      chk("async_rst_alu_dest", 32'(ifc.alu_dest), 32'd0);
      chk("async_rst_rs_full", 32'(ifc.rs_full), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      alu_bc(28, 32'h28); tick(); idle();
      repeat (4) tick();

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
# reservation_station

Receiving end of the dispatcher→RS interface: buffers dispatched non-load/store instructions and tracks operand tags. It snoops the ALU and LSB result broadcast buses and issues at most one ready instruction per cycle to the ALU. It drives `rs_full` back to the dispatcher for flow control.

## Interface
- `ENTRIES`, 8: number of station slots (power of two, ≥4).
- `TAG_W`, 5: operand/destination tag width; tag 0 means "value present, no dependency".
- `OP_W`, 6: optype width.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  rising-edge clock (single clock domain).
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  global enable; low = freeze all state and outputs.
- `clear`  in  1  flush (mispredict); drops all entries.
- `ena_rs`  in  1  dispatch valid.
- `optype_in`  in  OP_W  operation.
- `pc_in`  in  XLEN  instruction PC.
- `Qi_in`  in  TAG_W  rs1 tag.
- `Qj_in`  in  TAG_W  rs2 tag.
- `Vi_in`  in  XLEN  rs1 value, valid when `Qi_in`=0.
- `Vj_in`  in  XLEN  rs2 value, valid when `Qj_in`=0.
- `imm_in`  in  XLEN  immediate.
- `dest_in`  in  TAG_W  destination ROB tag (non-zero).
- `rs_full`  out  1  backpressure to dispatcher.
- `alu_cdb_valid`  in  1  ALU broadcast valid.
- `alu_cdb_tag`  in  TAG_W  ALU broadcast tag.
- `alu_cdb_val`  in  XLEN  ALU broadcast value.
- `lsb_cdb_valid`  in  1  LSB broadcast valid.
- `lsb_cdb_tag`  in  TAG_W  LSB broadcast tag.
- `lsb_cdb_val`  in  XLEN  LSB broadcast value.
- `alu_ena`  out  1  issue valid (registered).
- `alu_optype`  out  OP_W  issued op.
- `alu_pc`  out  XLEN  issued PC.
- `alu_vi`  out  XLEN  issued rs1 value.
- `alu_vj`  out  XLEN  issued rs2 value.
- `alu_imm`  out  XLEN  issued immediate.
- `alu_dest`  out  TAG_W  issued destination tag.

## Operation
- Per-entry state: busy, optype, pc, Qi, Qj, Vi, Vj, imm, dest.
- Allocation: on `ena_rs`, write lowest-index non-busy entry. If no free entry exists, it is a protocol violation: the request is dropped and state is unchanged.
- Insert bypass: if `Qi_in`≠0 matches a valid CDB tag in the same cycle, store that CDB value and set Qi=0. Same rule for Qj.
- Wakeup: each busy entry with Qx≠0 matching a valid CDB tag captures the value and sets Qx=0. Qi and Qj may both match one broadcast.
- If both buses carry the same tag, the ALU bus wins. A tag of 0 on a CDB is ignored.
- Issue select: lowest-index busy entry with Qi=0 and Qj=0, evaluated on registered state only. It is loaded into the `alu_*` output registers with `alu_ena`=1, and the entry is freed on the same edge.
- If nothing is ready: `alu_ena`=0 next cycle; data outputs hold.
- Entries inserted or woken at edge N are first eligible in the cycle after N.
- `rs_full` = 1 when free entries ≤ 1, computed combinationally from registered busy bits. The margin covers the dispatcher's one-cycle registered output.
- Simultaneous insert + issue: both occur. The slot freed by issue is not reused on the same edge.
- `clear` (when `rdy`=1): all busy bits clear and `alu_ena`=0 at the next edge. It overrides insert, wakeup and issue that cycle.
- `rdy`=0: no state or output changes; inputs ignored.

## Timing
- Reset (async, immediate): all busy=0, `alu_ena`=0, all `alu_*` data outputs=0, `rs_full`=0.
- Dispatch latency: `ena_rs` sampled at edge N with both operands ready (or bypassed) → `alu_ena`=1 after edge N+1.
- Wakeup latency: CDB tag match at edge N → issue no earlier than edge N+1.
- `alu_ena` is a one-cycle pulse per issued instruction. At most one issue per cycle.
- `rs_full` reflects state after the most recent edge.
- `rst` asserted mid-operation discards all entries and any pending issue immediately.

## Test plan
- Ready insert: `ena_rs` with Qi=Qj=0, Vi=5, Vj=7, dest=3 at edge N → `alu_ena`=1, `alu_vi`=5, `alu_vj`=7, `alu_dest`=3 after N+1, then `alu_ena`=0.
- Wakeup: insert Qi=4, Vj=2, Qj=0; two cycles later `lsb_cdb` tag=4 val=0x100 → issue one edge later with `alu_vi`=0x100; no issue before.
- Insert bypass: insert Qi=6 while `alu_cdb` tag=6 val=9 in the same cycle → issue after next edge with `alu_vi`=9.
- Fill: 7 inserts with unresolved tags on 8 entries → `rs_full`=1 after the 7th edge; a broadcast resolving one entry → issue, then `rs_full`=0. An 9th-entry write at full leaves state unchanged.
- Ordering: entries 0 and 2 woken by the same broadcast → entry 0 issues first, entry 2 on the next edge.
- Flush/freeze: `clear` with 3 busy entries → next cycle none busy, `alu_ena`=0. With `rdy`=0 over 3 cycles of CDB activity, nothing changes. Async `rst` mid-issue forces `alu_ena`=0 without a clock edge.
